// File: rtl/result_trace_logger.sv
// result_trace_logger
// Captures the per-cycle CPU result and flags ({N,Z,CO,OVF,cpu_out}) into a
// trace FIFO. The read side is show-ahead and drained through a valid/ready
// handshake. An optional value trigger freezes capture, so the cycles leading
// up to a chosen result stay in the FIFO for post-mortem inspection.
//
// Handshake: an entry transfers on every rising edge where rd_valid and
// rd_ready are both high. rd_valid depends only on registered state, never on
// rd_ready. rd_data holds steady while rd_valid is high and no transfer
// happens, and reads as zero while rd_valid is low.
module result_trace_logger #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [31:0]       cpu_out,
  input  logic              N,
  input  logic              Z,
  input  logic              CO,
  input  logic              OVF,
  input  logic              trig_en,
  input  logic [31:0]       trig_value,
  input  logic              rearm,
  output logic              rd_valid,
  output logic [35:0]       rd_data,
  input  logic              rd_ready,
  output logic [AW:0]       count,
  output logic [DROP_W-1:0] drop_count,
  output logic              stopped
);

  typedef enum logic {
    CAPTURE = 1'b0,
    STOPPED = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [35:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  logic [DROP_W-1:0] drop_q;
  logic              stopped_q;

  logic candidate;
  logic pop;
  logic push;
  logic drop;
  logic fire;

  // Datapath qualifiers. A pop on a full FIFO frees the slot the push needs.
  always_comb begin
    candidate = (state == CAPTURE) && cap_en;
    pop       = rd_valid && rd_ready;
    push      = candidate && ((count_q != FULL_COUNT) || pop);
    drop      = candidate && !push;
    fire      = candidate && trig_en && (cpu_out == trig_value);
  end

  // Next-state logic: a trigger fire always wins over rearm in CAPTURE.
  always_comb begin
    state_next = state;
    case (state)
      CAPTURE: if (fire)  state_next = STOPPED;
      STOPPED: if (rearm) state_next = CAPTURE;
      default: state_next = CAPTURE;
    endcase
  end

  // State register plus its registered decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CAPTURE;
      stopped_q <= 1'b0;
    end else begin
      state     <= state_next;
      stopped_q <= (state_next == STOPPED);
    end
  end

  // Pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  // Trace storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {N, Z, CO, OVF, cpu_out};
  end

  // Show-ahead read port, gated to zero when empty.
  always_comb begin
    rd_valid = (count_q != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : 36'h0;
  end

  assign count      = count_q;
  assign drop_count = drop_q;
  assign stopped    = stopped_q;

endmodule

// File: doc/result_trace_logger.md
Name: result_trace_logger

Overview:
- Capture-side counterpart to the vector-driven result checker.
- Records the per-cycle single-cycle CPU result (out plus N/Z/CO/OVF) into an on-chip trace FIFO.
- A host, bench or debug port drains the FIFO through a valid/ready read handshake.
- An optional value trigger freezes capture, so the cycles leading up to a specific result are kept for post-mortem comparison against expected vectors.

Parameters:
- DEPTH, 16, trace entries. Power of two, at least 2.
- AW, 4, pointer width. Must equal log2(DEPTH).
- DROP_W, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cap_en  in  1  sample qualifier; the current cycle's result is a capture candidate when high.
- cpu_out  in  32  CPU result bus.
- N  in  1  negative flag.
- Z  in  1  zero flag.
- CO  in  1  carry flag.
- OVF  in  1  overflow flag.
- trig_en  in  1  enables the stop trigger.
- trig_value  in  32  cpu_out value that fires the trigger.
- rearm  in  1  one-cycle pulse; leaves STOPPED.
- rd_valid  out  1  head entry available.
- rd_data  out  36  head entry, packed as {N,Z,CO,OVF,cpu_out}.
- rd_ready  in  1  consumer accepts the head entry.
- count  out  AW+1  entries held, 0..DEPTH.
- drop_count  out  DROP_W  candidates lost because the FIFO was full; saturating.
- stopped  out  1  high in STOPPED state.

Behaviour:
- Reset values (reset high at a rising edge):
  - write pointer, read pointer and count = 0.
  - drop_count = 0.
  - state = CAPTURE, so stopped = 0.
  - rd_valid = 0 and rd_data = 0.
  - Memory contents are not reset.
  - Reset mid-stream discards all entries and any pending trigger or stop.
- Candidate definition: candidate = (state==CAPTURE) && cap_en.
- pop = rd_valid && rd_ready.
  - rd_ready while rd_valid=0 has no effect.
- push = candidate && (count<DEPTH || pop).
  - When full, a simultaneous pop frees a slot, so the push succeeds.
- Drop: candidate && !push increments drop_count, saturating at all-ones (no wrap).
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Pointers advance modulo DEPTH, wrapping from DEPTH-1 to 0.
- Read side is show-ahead:
  - rd_valid = (count != 0).
  - rd_data = mem[read pointer] when rd_valid=1, otherwise 36'h0.
- Latency: a sample pushed at edge k appears on rd_data/rd_valid in the cycle after edge k, with no extra pipeline stage.
- Push into an empty FIFO with rd_ready high: no pop occurs that cycle (rd_valid was 0).
- Ordering is strict FIFO; no entry is duplicated or reordered.
- Trigger firing condition: candidate && trig_en && cpu_out==trig_value.
  - The triggering sample is pushed if there is room; otherwise it is dropped and counted.
  - At the same edge, the state moves to STOPPED.
- STOPPED state:
  - No candidates; drop_count is frozen.
  - Reads continue normally.
- State machine:
  - CAPTURE -> STOPPED on trigger fire.
  - STOPPED -> CAPTURE on rearm; takes effect at the next edge, and the FIFO contents are kept.
  - rearm in CAPTURE is ignored, including when it coincides with a trigger fire (STOPPED wins).
  - cap_en and trig_en are ignored in STOPPED.
- stopped is a registered decode of the state.

Test Plan:
- Reset then fill: reset for 2 cycles; cap_en=1 with cpu_out=1..16 and rd_ready=0 -> count=16, rd_valid=1, rd_data=36'h0_00000001.
  - Sample 17 -> drop_count=1, count stays 16.
- Drain order: from full, rd_ready=1 for 16 cycles with cap_en=0 -> reads 1..16 in order, then count=0, rd_valid=0, rd_data=0.
- Full with simultaneous push and pop: count=16, cap_en=1, cpu_out=32'hAA, rd_ready=1 -> count stays 16, drop_count unchanged, 32'hAA becomes the tail entry.
- Wrap-around: push and pop continuously for 40 cycles with an incrementing cpu_out and flags N=1,Z=0,CO=1,OVF=0 -> every read equals {4'hA, value} in sequence, no drops.
- Trigger and rearm: trig_en=1, trig_value=32'h0000002A; stream 0x28,0x29,0x2A,0x2B -> stopped=1 after the 0x2A edge, FIFO holds 0x28..0x2A, 0x2B is not captured.
  - rearm pulse -> stopped=0, and the next sample is captured after the retained entries.
- Reset mid-operation: count=5 and STOPPED, then reset for 1 cycle -> count=0, drop_count=0, stopped=0, rd_valid=0.
  - Next sample captures normally.
